// File: rtl/audio_mix_dac.sv
// ---------------------------------------------------------------------------
// audio_mix_dac
//
// N-channel audio mixer followed by a first-order delta-sigma DAC.
//
// A frame starts when sample_strobe is seen in IDLE. At that edge every
// channel's sample and a shadow copy of every gain are latched. ACCUM then
// adds one scaled channel per clock. CLAMP saturates the sum to IN_W bits
// and publishes it on pcm_out. The modulator runs every clock and turns
// the current pcm_out into a pulse-density bitstream.
//
// Handshake semantics (there is no back-pressure):
//   sample_strobe is a one-cycle request. It is accepted only when busy is
//   low. A strobe seen while busy is dropped and sets the sticky overrun
//   flag. pcm_valid is a one-cycle pulse in the cycle pcm_out takes a new
//   value, and busy is already low in that cycle, so a strobe driven in the
//   pcm_valid cycle is accepted.
//
// Parameters:
//   CHANNELS  number of mixed sources (1..8)
//   IN_W      signed sample width per channel and width of pcm_out
//
// Optional feature macro: AUDIO_MIX_DITHER_EN
//   When defined, a 16-bit LFSR adds 0..3 LSBs of dither to the modulator
//   input, saturating at all-ones. When undefined, no LFSR exists and the
//   modulator input is exactly the offset-binary pcm_out.
//
// Ports:
//   clock          chipset clock; all state changes on the rising edge
//   reset          asynchronous, active-high; clears all state
//   sample_in      packed signed samples, channel 0 in the LSBs
//   sample_strobe  one-cycle pulse that starts a mix frame
//   gain_we        write enable for the live gain register of gain_ch
//   gain_ch        channel index for the gain write (>= CHANNELS ignored)
//   gain_data      unsigned gain, 4 = unity (0 mutes, 15 = 3.75x)
//   clip_clr       clears the sticky clip and overrun flags
//   busy           frame in progress
//   pcm_out        last clamped mix, signed
//   pcm_valid      one-cycle pulse when pcm_out updates
//   clip           sticky: a frame saturated
//   overrun        sticky: a strobe arrived while busy
//   dac_out        delta-sigma bitstream
//   fsm_state      current FSM state (0 IDLE, 1 ACCUM, 2 CLAMP)
// ---------------------------------------------------------------------------
module audio_mix_dac #(
    parameter int CHANNELS = 3,
    parameter int IN_W     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CHANNELS*IN_W-1:0] sample_in,
    input  logic                     sample_strobe,
    input  logic                     gain_we,
    input  logic [2:0]               gain_ch,
    input  logic [3:0]               gain_data,
    input  logic                     clip_clr,
    output logic                     busy,
    output logic [IN_W-1:0]          pcm_out,
    output logic                     pcm_valid,
    output logic                     clip,
    output logic                     overrun,
    output logic                     dac_out,
    output logic [1:0]               fsm_state
);

    // Enough headroom for CHANNELS products of IN_W+4 bits.
    localparam int ACC_W = IN_W + 4 + $clog2(CHANNELS + 1);

    localparam logic signed [ACC_W-1:0] MAX_P = {{(ACC_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_N = {{(ACC_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};
    localparam logic [2:0]              LAST_CH = 3'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CLAMP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic signed [IN_W-1:0]  samp_q   [CHANNELS];
    logic        [3:0]       gain_q   [CHANNELS];
    logic        [3:0]       shadow_q [CHANNELS];
    logic        [2:0]       ch_q;
    logic signed [ACC_W-1:0] acc_q;
    logic        [IN_W:0]    dsacc_q;

    // FSM control strobes
    logic start;
    logic step;
    logic finish;
    logic ovr_set;

    // ---------------------------------------------------------------
    // FSM: state register and next-state/control decode
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_strobe) begin
                    start   = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                step    = 1'b1;
                ovr_set = sample_strobe;
                if (ch_q == LAST_CH) begin
                    state_d = CLAMP;
                end
            end
            CLAMP: begin
                finish  = 1'b1;
                ovr_set = sample_strobe;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fsm_state = state_q;

    // ---------------------------------------------------------------
    // Datapath: select the current channel, scale it, sign-extend
    // ---------------------------------------------------------------
    logic signed [IN_W-1:0]  sel_s;
    logic        [3:0]       sel_g;
    logic signed [IN_W+3:0]  s_ext;
    logic signed [IN_W+3:0]  g_ext;
    logic signed [IN_W+3:0]  prod;
    logic signed [IN_W+3:0]  scaled;
    logic signed [ACC_W-1:0] term;

    always_comb begin
        sel_s = '0;
        sel_g = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_q == 3'(i)) begin
                sel_s = samp_q[i];
                sel_g = shadow_q[i];
            end
        end
    end

    always_comb begin
        s_ext  = {{4{sel_s[IN_W-1]}}, sel_s};
        g_ext  = {{IN_W{1'b0}}, sel_g};
        prod   = s_ext * g_ext;
        // Gain unit is 4: arithmetic shift floors toward minus infinity.
        scaled = prod >>> 2;
        term   = {{(ACC_W-IN_W-4){scaled[IN_W+3]}}, scaled};
    end

    logic sat_hi;
    logic sat_lo;
    logic [IN_W-1:0] clamped;

    always_comb begin
        sat_hi = (acc_q > MAX_P);
        sat_lo = (acc_q < MIN_N);
        if (sat_hi) begin
            clamped = {1'b0, {(IN_W-1){1'b1}}};
        end else if (sat_lo) begin
            clamped = {1'b1, {(IN_W-1){1'b0}}};
        end else begin
            clamped = acc_q[IN_W-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                samp_q[i]   <= '0;
                gain_q[i]   <= 4'd4;
                shadow_q[i] <= '0;
            end
            ch_q      <= '0;
            acc_q     <= '0;
            busy      <= 1'b0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Live gains; the shadow copy below isolates a running frame.
            for (int i = 0; i < CHANNELS; i++) begin
                if (gain_we && (gain_ch == 3'(i))) begin
                    gain_q[i] <= gain_data;
                end
            end

            if (start) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    samp_q[i]   <= sample_in[i*IN_W +: IN_W];
                    shadow_q[i] <= gain_q[i];
                end
                acc_q <= '0;
                ch_q  <= '0;
                busy  <= 1'b1;
            end

            if (step) begin
                acc_q <= acc_q + term;
                ch_q  <= ch_q + 3'd1;
            end

            pcm_valid <= finish;
            if (finish) begin
                pcm_out <= clamped;
                busy    <= 1'b0;
            end

            // A same-cycle set beats clip_clr.
            clip    <= (finish & (sat_hi | sat_lo)) | (clip & ~clip_clr);
            overrun <= ovr_set | (overrun & ~clip_clr);
        end
    end

    // ---------------------------------------------------------------
    // First-order delta-sigma modulator (free-running)
    // ---------------------------------------------------------------
    logic [IN_W-1:0] u;
    logic [IN_W-1:0] mod_in;

    // Offset binary: most negative pcm maps to 0, most positive to all-ones.
    assign u = {~pcm_out[IN_W-1], pcm_out[IN_W-2:0]};

`ifdef AUDIO_MIX_DITHER_EN
    logic [15:0]   lfsr_q;
    logic [IN_W:0] dsum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            // Fibonacci taps 16,14,13,11
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_comb begin
        dsum   = {1'b0, u} + {{(IN_W-1){1'b0}}, lfsr_q[1:0]};
        mod_in = dsum[IN_W] ? {IN_W{1'b1}} : dsum[IN_W-1:0];
    end
`else
    assign mod_in = u;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dsacc_q <= '0;
            dac_out <= 1'b0;
        end else begin
            // The carry out of the previous add is the output bit.
            dsacc_q <= {1'b0, dsacc_q[IN_W-1:0]} + {1'b0, mod_in};
            dac_out <= dsacc_q[IN_W];
        end
    end

endmodule

// File: tb/tb_audio_mix_dac.sv
// ---------------------------------------------------------------------------
// tb_audio_mix_dac
//
// Self-checking bench for audio_mix_dac. A frame-level model computes each
// mix with integer arithmetic when a strobe is accepted and schedules its
// publication CHANNELS+1 edges later; the modulator is modelled as a
// modulo-2^IN_W accumulator whose carry is the output bit, seen one edge
// late. A compare process checks every output against the model each
// cycle; directed frames pin the model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_audio_mix_dac;

  localparam int CHANNELS = 3;
  localparam int IN_W     = 16;
  localparam int FULL     = 1 << IN_W;
  localparam int HALF     = 1 << (IN_W - 1);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [CHANNELS*IN_W-1:0] sample_in = '0;
  logic                     sample_strobe = 1'b0;
  logic                     gain_we = 1'b0;
  logic [2:0]               gain_ch = '0;
  logic [3:0]               gain_data = '0;
  logic                     clip_clr = 1'b0;
  logic                     busy;
  logic [IN_W-1:0]          pcm_out;
  logic                     pcm_valid;
  logic                     clip;
  logic                     overrun;
  logic                     dac_out;
  logic [1:0]               fsm_state;

  audio_mix_dac #(.CHANNELS(CHANNELS), .IN_W(IN_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_strobe (sample_strobe),
    .gain_we       (gain_we),
    .gain_ch       (gain_ch),
    .gain_data     (gain_data),
    .clip_clr      (clip_clr),
    .busy          (busy),
    .pcm_out       (pcm_out),
    .pcm_valid     (pcm_valid),
    .clip          (clip),
    .overrun       (overrun),
    .dac_out       (dac_out),
    .fsm_state     (fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_gain [8];
  int m_pcm, m_res, m_end, m_lo, edge_n, m_u, m_sum, m_s;
  bit m_valid, m_busy, m_clip, m_ovr, m_dac, m_carry, m_sat, pre_busy, clip_set, ovr_set;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_gain[i] = 4;
      m_pcm = 0; m_res = 0; m_end = 0; m_lo = 0; edge_n = 0;
      m_valid = 0; m_busy = 0; m_clip = 0; m_ovr = 0; m_dac = 0; m_carry = 0; m_sat = 0;
    end else begin
      edge_n++;
      // modulator sees pcm_out as it was before this edge
      m_u     = m_pcm ^ HALF;
      m_dac   = m_carry;
      m_carry = (m_lo + m_u) >= FULL;
      m_lo    = (m_lo + m_u) % FULL;

      pre_busy = m_busy;
      clip_set = 0;
      ovr_set  = 0;
      m_valid  = 0;
      if (m_busy && edge_n == m_end) begin
        m_pcm    = m_res;
        m_valid  = 1;
        clip_set = m_sat;
        m_busy   = 0;
      end
      if (sample_strobe) begin
        if (pre_busy) begin
          ovr_set = 1;
        end else begin
          m_sum = 0;
          for (int c = 0; c < CHANNELS; c++) begin
            m_s   = $signed(sample_in[c*IN_W +: IN_W]);
            m_sum = m_sum + ((m_s * m_gain[c]) >>> 2);
          end
          m_sat = 0;
          if (m_sum > HALF - 1) begin m_sum = HALF - 1; m_sat = 1; end
          if (m_sum < -HALF)    begin m_sum = -HALF;    m_sat = 1; end
          m_res  = m_sum & (FULL - 1);
          m_end  = edge_n + CHANNELS + 1;
          m_busy = 1;
        end
      end
      if (gain_we && gain_ch < CHANNELS) m_gain[gain_ch] = gain_data;
      m_clip = clip_set | (m_clip & !clip_clr);
      m_ovr  = ovr_set  | (m_ovr  & !clip_clr);
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clock) begin
    #1;
    chk("cmp_busy",      busy,      m_busy);
    chk("cmp_pcm_out",   pcm_out,   m_pcm);
    chk("cmp_pcm_valid", pcm_valid, m_valid);
    chk("cmp_clip",      clip,      m_clip);
    chk("cmp_overrun",   overrun,   m_ovr);
    chk("cmp_dac_out",   dac_out,   m_dac);
  end

  // ---------------- driver tasks ----------------
  task automatic set_gain(input int ch, input int g);
    @(negedge clock);
    gain_we = 1'b1; gain_ch = 3'(ch); gain_data = 4'(g);
    @(negedge clock);
    gain_we = 1'b0;
  endtask

  task automatic pulse_clip_clr();
    @(negedge clock);
    clip_clr = 1'b1;
    @(negedge clock);
    clip_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Strobe once, then watch a bounded window. Optional mid-frame gain
  // write at window step gw_at and second strobe at step ov_at.
  task automatic run_frame(input logic [CHANNELS*IN_W-1:0] s,
                           input int gw_at, input int gw_ch, input int gw_val,
                           input int ov_at, input logic [CHANNELS*IN_W-1:0] s2,
                           output logic [IN_W-1:0] res, output int lat, output int vcnt);
    @(negedge clock);
    sample_in = s; sample_strobe = 1'b1;
    lat = -1; vcnt = 0; res = '0;
    for (int k = 1; k <= CHANNELS + 6; k++) begin
      @(negedge clock);
      if (pcm_valid) begin
        vcnt++;
        if (lat < 0) begin lat = k; res = pcm_out; end
      end
      sample_strobe = (k == ov_at);
      if (k == ov_at) sample_in = s2;
      gain_we   = (k == gw_at);
      gain_ch   = 3'(gw_ch);
      gain_data = 4'(gw_val);
    end
    sample_strobe = 1'b0;
    gain_we = 1'b0;
  endtask

  task automatic simple_frame(input string name, input logic [CHANNELS*IN_W-1:0] s,
                              input logic [IN_W-1:0] exp_res);
    logic [IN_W-1:0] res;
    int lat, vcnt;
    run_frame(s, -1, 0, 0, -1, '0, res, lat, vcnt);
    chk({name, "_pcm"}, res, exp_res);
    chk({name, "_latency"}, lat, CHANNELS + 2);
    chk({name, "_one_valid"}, vcnt, 1);
  endtask

  function automatic logic [CHANNELS*IN_W-1:0] pack3(input logic [15:0] c2, input logic [15:0] c1,
                                                     input logic [15:0] c0);
    return {c2, c1, c0};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [IN_W-1:0] res;
    int lat, vcnt, ones, toggles;
    logic prev;

    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_pcm_out", pcm_out, 0);
    chk("reset_pcm_valid", pcm_valid, 0);
    chk("reset_clip", clip, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_dac_out", dac_out, 0);
    reset = 1'b0;

    // unity gain, single active channel
    simple_frame("unity", pack3(16'h0000, 16'h0000, 16'h1000), 16'h1000);
    chk("model_pin_unity", m_pcm, 16'h1000);
    chk("unity_clip", clip, 0);

    // positive and negative saturation, then clear
    simple_frame("sat_pos", pack3(16'h7000, 16'h7000, 16'h7000), 16'h7FFF);
    chk("sat_pos_clip", clip, 1);
    simple_frame("sat_neg", pack3(16'h9000, 16'h9000, 16'h9000), 16'h8000);
    chk("model_pin_sat_neg", m_pcm, 16'h8000);
    pulse_clip_clr();
    chk("clip_cleared", clip, 0);

    // gains: mute ch1, double ch0
    set_gain(1, 0);
    set_gain(0, 8);
    simple_frame("gain", pack3(16'h0000, 16'h7FFF, 16'h0100), 16'h0200);

    // gain write during a frame only affects the next frame
    run_frame(pack3(16'h0000, 16'h7FFF, 16'h0100), 1, 0, 15, -1, '0, res, lat, vcnt);
    chk("midframe_gain_pcm", res, 16'h0200);
    simple_frame("next_gain", pack3(16'h0000, 16'h7FFF, 16'h0100), 16'h03C0);

    // second strobe two cycles into a frame
    run_frame(pack3(16'h0000, 16'h0000, 16'h0100), -1, 0, 0, 2, pack3(16'h0000, 16'h0000, 16'h2000),
              res, lat, vcnt);
    chk("overrun_pcm", res, 16'h03C0);
    chk("overrun_one_valid", vcnt, 1);
    chk("overrun_flag", overrun, 1);
    pulse_clip_clr();
    chk("overrun_cleared", overrun, 0);

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      for (int c = 0; c < CHANNELS; c++) begin
        if ($urandom_range(0, 1) == 0)
          sample_in[c*IN_W +: IN_W] = IN_W'($urandom);
        else
          sample_in[c*IN_W +: IN_W] = IN_W'(int'($urandom_range(0, 8191)) - 4096);
      end
      sample_strobe = ($urandom_range(0, 3) == 0);
      gain_we       = ($urandom_range(0, 7) == 0);
      gain_ch       = 3'($urandom_range(0, 7));
      gain_data     = 4'($urandom_range(0, 15));
      clip_clr      = ($urandom_range(0, 15) == 0);
    end
    @(negedge clock);
    sample_strobe = 1'b0; gain_we = 1'b0; clip_clr = 1'b0;
    repeat (CHANNELS + 3) @(negedge clock);

    // density at pcm_out = 0x4000: 3/4 ones
    do_reset();
    simple_frame("dens_frame", pack3(16'h0000, 16'h0000, 16'h4000), 16'h4000);
    ones = 0;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clock);
      ones += dac_out;
    end
    chk("density_4000", ones, 49152);

    // reset two cycles into a frame
    @(negedge clock);
    sample_in = pack3(16'h0000, 16'h0000, 16'h0800); sample_strobe = 1'b1;
    @(negedge clock);
    sample_strobe = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_pcm_valid", pcm_valid, 0);
    chk("midreset_pcm_out", pcm_out, 0);
    chk("midreset_clip", clip, 0);
    @(negedge clock);
    reset = 1'b0;
    simple_frame("post_reset", pack3(16'h0123, 16'h0100, 16'h0800), 16'h0A23);

    // pcm_out = 0 gives an alternating bitstream
    simple_frame("zero_frame", pack3(16'h0000, 16'h0000, 16'h0000), 16'h0000);
    toggles = 0;
    @(negedge clock);
    prev = dac_out;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      if (dac_out != prev) toggles++;
      prev = dac_out;
    end
    chk("density_zero_alternates", toggles, 32);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
